// File: rtl/phone_cmd_decoder.sv
// phone_cmd_decoder: decodes framed bluetooth commands from the phone.
// Frame: AA cmd len payload[len] chk, where chk = cmd ^ len ^ payload.
// Ports:
//   clk, rst_n          : 50 MHz clock, async active-low reset
//   received, rx_byte   : UART byte strobe and data
//   ack_taken           : transmitter consumed the ping acknowledge
//   heartCap            : heart-rate cap in bpm (clamped)
//   assistLevel         : assist level 0..7
//   lightCmd            : bit0 headlight override, bit1 hazard blink
//   cmd_valid/err_pulse : one-cycle accept / reject pulses
//   ack_req             : held ping acknowledge request
//   err_code            : last error (1 chk, 2 len, 3 cmd, 4 timeout)
module phone_cmd_decoder #(
   parameter int TIMEOUT_CYCLES = 500000,
   parameter int HR_MIN         = 60,
   parameter int HR_MAX         = 220
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       received,
   input  logic [7:0] rx_byte,
   input  logic       ack_taken,
   output logic [7:0] heartCap,
   output logic [2:0] assistLevel,
   output logic [1:0] lightCmd,
   output logic       cmd_valid,
   output logic       ack_req,
   output logic       err_pulse,
   output logic [2:0] err_code
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] HR_LO = 8'(HR_MIN);
   localparam logic [7:0] HR_HI = 8'(HR_MAX);
   localparam logic [7:0] SYNC  = 8'hAA;

   localparam logic [2:0] E_CHK = 3'd1;
   localparam logic [2:0] E_LEN = 3'd2;
   localparam logic [2:0] E_CMD = 3'd3;
   localparam logic [2:0] E_TMO = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_LEN,
      S_PAYLOAD,
      S_CHK
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [7:0]    r_cmd;
   logic [2:0]    r_len;
   logic [2:0]    r_idx;
   logic [7:0]    r_xor;
   logic [7:0]    r_pay [4];
   logic [TW-1:0] r_tmo;

   logic [7:0] r_heart;
   logic [2:0] r_assist;
   logic [1:0] r_light;
   logic       r_valid;
   logic       r_ack;
   logic       r_err;
   logic [2:0] r_err_code;

   logic       w_tmo;
   logic       w_last_pay;
   logic       w_err;
   logic [2:0] w_err_code;
   logic       w_set_hr;
   logic       w_set_as;
   logic       w_set_lt;
   logic       w_set_ack;
   logic       w_valid;
   logic [7:0] w_hr_clamped;
   logic [2:0] w_as_sat;

   // A byte arriving on the expiry cycle takes priority over the timeout.
   assign w_tmo = (r_state != S_IDLE) && !received && (r_tmo == TMO_LAST);
   assign w_last_pay = (r_idx == (r_len - 3'd1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      if (w_tmo) begin
         w_next = S_IDLE;
      end else if (received) begin
         unique case (r_state)
            S_IDLE: begin
               if (rx_byte == SYNC) w_next = S_CMD;
            end
            S_CMD: begin
               w_next = S_LEN;
            end
            S_LEN: begin
               if (rx_byte > 8'd4)       w_next = S_IDLE;
               else if (rx_byte == 8'd0) w_next = S_CHK;
               else                      w_next = S_PAYLOAD;
            end
            S_PAYLOAD: begin
               if (w_last_pay) w_next = S_CHK;
            end
            S_CHK: begin
               w_next = S_IDLE;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   // Output decode: accept/reject decisions for this cycle
   always_comb begin
      w_err      = 1'b0;
      w_err_code = 3'd0;
      w_set_hr   = 1'b0;
      w_set_as   = 1'b0;
      w_set_lt   = 1'b0;
      w_set_ack  = 1'b0;
      if (w_tmo) begin
         w_err      = 1'b1;
         w_err_code = E_TMO;
      end else if (received) begin
         if (r_state == S_LEN && rx_byte > 8'd4) begin
            w_err      = 1'b1;
            w_err_code = E_LEN;
         end else if (r_state == S_CHK) begin
            if (rx_byte != r_xor) begin
               w_err      = 1'b1;
               w_err_code = E_CHK;
            end else begin
               case (r_cmd)
                  8'h01: begin
                     if (r_len == 3'd1) w_set_hr = 1'b1;
                     else begin w_err = 1'b1; w_err_code = E_LEN; end
                  end
                  8'h02: begin
                     if (r_len == 3'd1) w_set_as = 1'b1;
                     else begin w_err = 1'b1; w_err_code = E_LEN; end
                  end
                  8'h03: begin
                     if (r_len == 3'd1) w_set_lt = 1'b1;
                     else begin w_err = 1'b1; w_err_code = E_LEN; end
                  end
                  8'h04: begin
                     if (r_len == 3'd0) w_set_ack = 1'b1;
                     else begin w_err = 1'b1; w_err_code = E_LEN; end
                  end
                  default: begin
                     w_err      = 1'b1;
                     w_err_code = E_CMD;
                  end
               endcase
            end
         end
      end
   end

   assign w_valid = w_set_hr | w_set_as | w_set_lt | w_set_ack;

   always_comb begin
      w_hr_clamped = r_pay[0];
      if (r_pay[0] < HR_LO)      w_hr_clamped = HR_LO;
      else if (r_pay[0] > HR_HI) w_hr_clamped = HR_HI;
   end

   assign w_as_sat = (r_pay[0] > 8'd7) ? 3'd7 : r_pay[0][2:0];

   // Frame capture, running checksum and inter-byte timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd <= 8'd0;
         r_len <= 3'd0;
         r_idx <= 3'd0;
         r_xor <= 8'd0;
         r_tmo <= '0;
         for (int i = 0; i < 4; i++) r_pay[i] <= 8'd0;
      end else begin
         if (w_next == S_IDLE || received) r_tmo <= '0;
         else                             r_tmo <= r_tmo + 1'b1;
         if (received) begin
            case (r_state)
               S_CMD: begin
                  r_cmd <= rx_byte;
                  r_xor <= rx_byte;
               end
               S_LEN: begin
                  r_len <= rx_byte[2:0];
                  r_idx <= 3'd0;
                  r_xor <= r_xor ^ rx_byte;
               end
               S_PAYLOAD: begin
                  r_pay[r_idx[1:0]] <= rx_byte;
                  r_idx <= r_idx + 3'd1;
                  r_xor <= r_xor ^ rx_byte;
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_heart    <= 8'd200;
         r_assist   <= 3'd0;
         r_light    <= 2'd0;
         r_valid    <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 3'd0;
      end else begin
         r_valid <= w_valid;
         r_err   <= w_err;
         if (w_err)    r_err_code <= w_err_code;
         if (w_set_hr) r_heart    <= w_hr_clamped;
         if (w_set_as) r_assist   <= w_as_sat;
         if (w_set_lt) r_light    <= r_pay[0][1:0];
         // A new ping wins over a simultaneous ack_taken.
         r_ack <= w_set_ack | (r_ack & ~ack_taken);
      end
   end

   assign heartCap    = r_heart;
   assign assistLevel = r_assist;
   assign lightCmd    = r_light;
   assign cmd_valid   = r_valid;
   assign ack_req     = r_ack;
   assign err_pulse   = r_err;
   assign err_code    = r_err_code;

endmodule

// File: tb/tb_phone_cmd_decoder.sv
// tb_phone_cmd_decoder: directed tests for phone_cmd_decoder.
// Checksums in frames follow chk = cmd ^ len ^ payload.
module tb_phone_cmd_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       received = 1'b0;
   logic [7:0] rx_byte = 8'd0;
   logic       ack_taken = 1'b0;
   logic [7:0] heartCap;
   logic [2:0] assistLevel;
   logic [1:0] lightCmd;
   logic       cmd_valid;
   logic       ack_req;
   logic       err_pulse;
   logic [2:0] err_code;

   int tests = 0;
   int fails = 0;

   phone_cmd_decoder #(
      .TIMEOUT_CYCLES(100),
      .HR_MIN(60),
      .HR_MAX(220)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .received(received),
      .rx_byte(rx_byte),
      .ack_taken(ack_taken),
      .heartCap(heartCap),
      .assistLevel(assistLevel),
      .lightCmd(lightCmd),
      .cmd_valid(cmd_valid),
      .ack_req(ack_req),
      .err_pulse(err_pulse),
      .err_code(err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Caller is at a negedge; the strobe edge is the next posedge.
   task automatic send_byte(input logic [7:0] b);
      received = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      received = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] f[], input int n);
      for (int i = 0; i < n; i++) send_byte(f[i]);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (heartCap !== 8'd200) begin fails++; $display("FAIL rst_heart: got %0d want 200", heartCap); end
      tests++; if (assistLevel !== 3'd0) begin fails++; $display("FAIL rst_assist: got %0d want 0", assistLevel); end
      tests++; if (lightCmd !== 2'd0) begin fails++; $display("FAIL rst_light: got %0d want 0", lightCmd); end
      tests++; if ({cmd_valid, ack_req, err_pulse} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b want 000", {cmd_valid, ack_req, err_pulse}); end
      tests++; if (err_code !== 3'd0) begin fails++; $display("FAIL rst_errcode: got %0d want 0", err_code); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_heartcap;
      send_frame('{8'hAA, 8'h01, 8'h01, 8'h96, 8'h96}, 5);
      tests++; if (heartCap !== 8'd150) begin fails++; $display("FAIL hr_150: got %0d want 150", heartCap); end
      tests++; if (cmd_valid !== 1'b1) begin fails++; $display("FAIL hr_valid: got %b want 1", cmd_valid); end
      @(negedge clk);
      tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL hr_valid_once: got %b want 0", cmd_valid); end
      send_frame('{8'hAA, 8'h01, 8'h01, 8'hFA, 8'hFA}, 5);
      tests++; if (heartCap !== 8'd220) begin fails++; $display("FAIL hr_clamp_hi: got %0d want 220", heartCap); end
      send_frame('{8'hAA, 8'h01, 8'h01, 8'h0A, 8'h0A}, 5);
      tests++; if (heartCap !== 8'd60) begin fails++; $display("FAIL hr_clamp_lo: got %0d want 60", heartCap); end
      send_frame('{8'hAA, 8'h01, 8'h01, 8'hDC, 8'hDC}, 5);
      tests++; if (heartCap !== 8'd220) begin fails++; $display("FAIL hr_edge_hi: got %0d want 220", heartCap); end
      send_frame('{8'hAA, 8'h01, 8'h01, 8'h3B, 8'h3B}, 5);
      tests++; if (heartCap !== 8'd60) begin fails++; $display("FAIL hr_59: got %0d want 60", heartCap); end
      send_frame('{8'hAA, 8'h01, 8'h01, 8'h3D, 8'h3D}, 5);
      tests++; if (heartCap !== 8'd61) begin fails++; $display("FAIL hr_61: got %0d want 61", heartCap); end
   endtask

   task automatic test_assist;
      send_frame('{8'hAA, 8'h02, 8'h01, 8'h05, 8'h06}, 5);
      tests++; if (assistLevel !== 3'd5) begin fails++; $display("FAIL as_5: got %0d want 5", assistLevel); end
      send_frame('{8'hAA, 8'h02, 8'h01, 8'h09, 8'h0A}, 5);
      tests++; if (assistLevel !== 3'd7) begin fails++; $display("FAIL as_sat: got %0d want 7", assistLevel); end
   endtask

   task automatic test_checksum_err;
      send_frame('{8'hAA, 8'h02, 8'h01, 8'h05, 8'h07}, 5);
      tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL chk_pulse: got %b want 1", err_pulse); end
      tests++; if (err_code !== 3'd1) begin fails++; $display("FAIL chk_code: got %0d want 1", err_code); end
      tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL chk_novalid: got %b want 0", cmd_valid); end
      tests++; if (assistLevel !== 3'd7) begin fails++; $display("FAIL chk_assist: got %0d want 7", assistLevel); end
      @(negedge clk);
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL chk_pulse_once: got %b want 0", err_pulse); end
      tests++; if (err_code !== 3'd1) begin fails++; $display("FAIL chk_code_hold: got %0d want 1", err_code); end
   endtask

   task automatic test_lights;
      send_frame('{8'h55, 8'h13, 8'hAA, 8'h03, 8'h01, 8'h03, 8'h01}, 7);
      tests++; if (lightCmd !== 2'd3) begin fails++; $display("FAIL light_3: got %0d want 3", lightCmd); end
      tests++; if (err_code !== 3'd1) begin fails++; $display("FAIL idle_drop_noerr: got %0d want 1", err_code); end
   endtask

   task automatic test_ping;
      int bad;
      send_frame('{8'hAA, 8'h04, 8'h00, 8'h04}, 4);
      tests++; if (ack_req !== 1'b1) begin fails++; $display("FAIL ping_set: got %b want 1", ack_req); end
      tests++; if (cmd_valid !== 1'b1) begin fails++; $display("FAIL ping_valid: got %b want 1", cmd_valid); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack_req !== 1'b1) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL ping_hold: %0d low cycles, want 0", bad); end
      ack_taken = 1'b1;
      @(negedge clk);
      ack_taken = 1'b0;
      tests++; if (ack_req !== 1'b0) begin fails++; $display("FAIL ping_clear: got %b want 0", ack_req); end
      send_frame('{8'hAA, 8'h04, 8'h00, 8'h04}, 4);
      send_frame('{8'hAA, 8'h04, 8'h00}, 3);
      ack_taken = 1'b1;
      send_byte(8'h04);
      ack_taken = 1'b0;
      tests++; if (ack_req !== 1'b1) begin fails++; $display("FAIL ping_coincide: got %b want 1", ack_req); end
      ack_taken = 1'b1;
      @(negedge clk);
      ack_taken = 1'b0;
      tests++; if (ack_req !== 1'b0) begin fails++; $display("FAIL ping_clear2: got %b want 0", ack_req); end
   endtask

   task automatic test_bad_len;
      send_frame('{8'hAA, 8'h01, 8'h05}, 3);
      tests++; if (err_pulse !== 1'b1 || err_code !== 3'd2) begin fails++; $display("FAIL len5: got pulse %b code %0d want 1/2", err_pulse, err_code); end
      send_frame('{8'hAA, 8'h07, 8'h00, 8'h07}, 4);
      tests++; if (err_code !== 3'd3) begin fails++; $display("FAIL unknown_cmd: got %0d want 3", err_code); end
      send_frame('{8'hAA, 8'h01, 8'h00, 8'h01}, 4);
      tests++; if (err_code !== 3'd2) begin fails++; $display("FAIL known_wrong_len: got %0d want 2", err_code); end
      send_frame('{8'hAA, 8'h04, 8'h01, 8'h00, 8'h05}, 5);
      tests++; if (err_code !== 3'd2 || ack_req !== 1'b0) begin fails++; $display("FAIL ping_len1: got code %0d ack %b want 2/0", err_code, ack_req); end
      tests++; if (heartCap !== 8'd61) begin fails++; $display("FAIL err_no_update: got %0d want 61", heartCap); end
   endtask

   task automatic test_payload_aa;
      send_frame('{8'hAA, 8'h01, 8'h01, 8'hAA, 8'hAA}, 5);
      tests++; if (heartCap !== 8'd170 || cmd_valid !== 1'b1) begin fails++; $display("FAIL pay_aa: got %0d valid %b want 170/1", heartCap, cmd_valid); end
   endtask

   task automatic test_timeout;
      int n;
      n = 0;
      send_frame('{8'hAA, 8'h03}, 2);
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (err_pulse === 1'b1) begin
            n = i;
            break;
         end
      end
      tests++; if (n != 100) begin fails++; $display("FAIL tmo_cycles: got %0d want 100", n); end
      tests++; if (err_code !== 3'd4) begin fails++; $display("FAIL tmo_code: got %0d want 4", err_code); end
      @(negedge clk);
      send_frame('{8'hAA, 8'h03, 8'h01, 8'h02, 8'h00}, 5);
      tests++; if (lightCmd !== 2'd2) begin fails++; $display("FAIL tmo_recover: got %0d want 2", lightCmd); end
   endtask

   task automatic test_byte_wins;
      send_frame('{8'hAA, 8'h03}, 2);
      repeat (99) @(negedge clk);
      send_byte(8'h01);
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL byte_wins_err: got %b want 0", err_pulse); end
      send_frame('{8'h01, 8'h03}, 2);
      tests++; if (lightCmd !== 2'd1 || cmd_valid !== 1'b1) begin fails++; $display("FAIL byte_wins_frame: got %0d valid %b want 1/1", lightCmd, cmd_valid); end
   endtask

   task automatic test_back_to_back;
      send_frame('{8'hAA, 8'h02, 8'h01, 8'h03, 8'h00}, 5);
      tests++; if (assistLevel !== 3'd3 || cmd_valid !== 1'b1) begin fails++; $display("FAIL b2b_first: got %0d valid %b want 3/1", assistLevel, cmd_valid); end
      send_frame('{8'hAA, 8'h03, 8'h01, 8'h00, 8'h02}, 5);
      tests++; if (lightCmd !== 2'd0 || cmd_valid !== 1'b1) begin fails++; $display("FAIL b2b_second: got %0d valid %b want 0/1", lightCmd, cmd_valid); end
   endtask

   task automatic test_reset_midframe;
      send_frame('{8'hAA, 8'h04, 8'h00, 8'h04}, 4);
      send_frame('{8'hAA, 8'h01}, 2);
      rst_n = 1'b0;
      #1;
      tests++; if (heartCap !== 8'd200 || assistLevel !== 3'd0 || lightCmd !== 2'd0) begin fails++; $display("FAIL mid_rst_data: got %0d/%0d/%0d want 200/0/0", heartCap, assistLevel, lightCmd); end
      tests++; if (ack_req !== 1'b0 || err_code !== 3'd0) begin fails++; $display("FAIL mid_rst_flags: got ack %b code %0d want 0/0", ack_req, err_code); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame('{8'h01, 8'h01, 8'h64, 8'h64}, 4);
      tests++; if (heartCap !== 8'd200 || cmd_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_discard: got %0d valid %b want 200/0", heartCap, cmd_valid); end
      send_frame('{8'hAA, 8'h01, 8'h01, 8'h64, 8'h64}, 5);
      tests++; if (heartCap !== 8'd100) begin fails++; $display("FAIL mid_rst_next: got %0d want 100", heartCap); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_heartcap();
      test_assist();
      test_checksum_err();
      test_lights();
      test_ping();
      test_bad_len();
      test_payload_aa();
      test_timeout();
      test_byte_wins();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
